// File: rtl/jtag_scan_sequencer_if.sv
// Command/response bundle between a debug requester and the JTAG scan sequencer.
//   master : requester side (drives cmd_*, rsp_ready; receives cmd_ready, rsp_*)
//   slave  : sequencer side (the opposite directions)
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 TLR, 01 IR scan, 10 DR scan, 11 idle tck cycles
//   cmd_len              scan length in bits, or idle tck count
//   cmd_data             TDI data, bit 0 shifted first
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             captured TDO, first captured bit in bit 0
//   rsp_err              command was rejected (bad scan length)
interface jtag_scan_sequencer_if #(
    parameter int DR_MAX = 32,
    parameter int LW     = $clog2(DR_MAX + 1)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LW-1:0]     cmd_len;
    logic [DR_MAX-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DR_MAX-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: walks the TAP state machine from the sys_clk domain.
// After reset it parks the TAP in Run-Test/Idle with a TLR sequence, then
// accepts one command at a time (TLR, IR scan, DR scan, idle cycles) and
// returns one response with the captured TDO bits.
// Ports:
//   sys_clk  single clock, all logic on posedge
//   reset    synchronous, active-high
//   bus      command/response interface (slave modport)
//   tck      generated test clock, low whenever no tck pulse is in progress
//   tms/tdi  TAP controls, changed only while tck is low
//   tdo      TAP data, registered once before use
module jtag_scan_sequencer #(
    parameter int DR_MAX  = 32,
    parameter int CLK_DIV = 2,
    parameter int LW      = $clog2(DR_MAX + 1)
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    jtag_scan_sequencer_if.slave   bus,
    output logic                   tck,
    output logic                   tms,
    output logic                   tdi,
    input  logic                   tdo
);

    // tck counter holds up to 6 + 2^LW - 1 pulses without wrapping
    localparam int CW = LW + 3;
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [1:0] OP_TLR  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;

    localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0]     NTCK_TLR  = CW'(6);
    localparam logic [DR_MAX-1:0] BIT0_MASK = {{(DR_MAX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SYNC = 2'b00,
        ST_IDLE = 2'b01,
        ST_SCAN = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    state_t            state_r;
    logic [1:0]        op_r;
    logic [CW-1:0]     len_r;
    logic [DR_MAX-1:0] data_r;
    logic [CW-1:0]     ntck_r;
    logic [CW-1:0]     cnt_r;
    logic [DW-1:0]     div_r;
    logic              tdo_r;
    logic              tck_r;
    logic              tms_r;
    logic              tdi_r;
    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [DR_MAX-1:0] rsp_data_r;
    logic [CW-1:0]     new_len_s;

    // tck index at which shifting starts: IR enters Shift-IR after 4 tck, DR after 3
    function automatic logic [CW-1:0] shift_start(input logic [1:0] op);
        logic [CW-1:0] pre;
        case (op)
            OP_IR:   pre = CW'(4);
            OP_DR:   pre = CW'(3);
            default: pre = CW'(0);
        endcase
        return pre;
    endfunction

    // Total tck pulses for a command, Run-Test/Idle to Run-Test/Idle
    function automatic logic [CW-1:0] calc_ntck(input logic [1:0] op, input logic [CW-1:0] len);
        logic [CW-1:0] n;
        case (op)
            OP_TLR:  n = NTCK_TLR;
            OP_IR:   n = len + CW'(6);
            OP_DR:   n = len + CW'(5);
            default: n = len;
        endcase
        return n;
    endfunction

    // True when tck index k is a shift bit of an IR/DR scan
    function automatic logic is_shift(input logic [1:0] op, input logic [CW-1:0] len,
                                      input logic [CW-1:0] k);
        logic r;
        if ((op == OP_IR) || (op == OP_DR)) begin
            r = (k >= shift_start(op)) && (k < (shift_start(op) + len));
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // {tms, tdi} to present for tck index k; indices past the end give {0,0}
    function automatic logic [1:0] drive_bits(input logic [1:0] op, input logic [CW-1:0] len,
                                              input logic [CW-1:0] k, input logic [DR_MAX-1:0] data);
        logic          tms_v;
        logic          tdi_v;
        logic [CW-1:0] pre;
        pre   = shift_start(op);
        tdi_v = 1'b0;
        case (op)
            OP_TLR: begin
                tms_v = (k < CW'(5));
            end
            OP_IR, OP_DR: begin
                if (k < pre) begin
                    // IR: 1,1,0,0 (via Select-IR); DR: 1,0,0
                    tms_v = (op == OP_IR) ? (k < CW'(2)) : (k == CW'(0));
                end else if (k < (pre + len)) begin
                    // last shift bit leaves Shift-xR
                    tms_v = (k == (pre + len - CW'(1)));
                    tdi_v = |(data & (BIT0_MASK << (k - pre)));
                end else begin
                    // Exit1 -> Update (1), Update -> Run-Test/Idle (0)
                    tms_v = (k == (pre + len));
                end
            end
            default: begin
                tms_v = 1'b0;
            end
        endcase
        return {tms_v, tdi_v};
    endfunction

    assign new_len_s = {3'b000, bus.cmd_len};

    assign tck           = tck_r;
    assign tms           = tms_r;
    assign tdi           = tdi_r;
    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_data  = rsp_data_r;

    // Sequencer FSM, tck divider/pulse engine and all registered outputs
    always_ff @(posedge sys_clk) begin
        tdo_r <= tdo;
        if (reset) begin
            // abandon any scan and queue the post-reset TLR sequence
            state_r     <= ST_SYNC;
            op_r        <= OP_TLR;
            len_r       <= CW'(0);
            data_r      <= {DR_MAX{1'b0}};
            ntck_r      <= NTCK_TLR;
            cnt_r       <= CW'(0);
            div_r       <= DW'(0);
            tck_r       <= 1'b0;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= {DR_MAX{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        op_r        <= bus.cmd_op;
                        len_r       <= new_len_s;
                        data_r      <= bus.cmd_data;
                        ntck_r      <= calc_ntck(bus.cmd_op, new_len_s);
                        cmd_ready_r <= 1'b0;
                        cnt_r       <= CW'(0);
                        div_r       <= DW'(0);
                        tck_r       <= 1'b0;
                        rsp_data_r  <= {DR_MAX{1'b0}};
                        if (((bus.cmd_op == OP_IR) || (bus.cmd_op == OP_DR)) &&
                            ((bus.cmd_len == LW'(0)) || (bus.cmd_len > LW'(DR_MAX)))) begin
                            // rejected scan: no tck at all
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                        end else if (calc_ntck(bus.cmd_op, new_len_s) == CW'(0)) begin
                            // idle of zero cycles completes at once
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                        end else begin
                            state_r        <= ST_SCAN;
                            rsp_err_r      <= 1'b0;
                            {tms_r, tdi_r} <= drive_bits(bus.cmd_op, new_len_s, CW'(0), bus.cmd_data);
                        end
                    end
                end
                ST_SYNC, ST_SCAN: begin
                    if (!tck_r) begin
                        if (cnt_r == ntck_r) begin
                            // one cycle after the final falling edge
                            if (state_r == ST_SYNC) begin
                                state_r     <= ST_IDLE;
                                cmd_ready_r <= 1'b1;
                            end else begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                            end
                        end else if (div_r == DIV_LAST) begin
                            tck_r <= 1'b1;
                            div_r <= DW'(0);
                            if (is_shift(op_r, len_r, cnt_r)) begin
                                rsp_data_r <= rsp_data_r |
                                              ({{(DR_MAX-1){1'b0}}, tdo_r} << (cnt_r - shift_start(op_r)));
                            end
                        end else begin
                            div_r <= div_r + DW'(1);
                        end
                    end else begin
                        if (div_r == DIV_LAST) begin
                            // falling edge: advance and present the next tms/tdi
                            tck_r          <= 1'b0;
                            div_r          <= DW'(0);
                            cnt_r          <= cnt_r + CW'(1);
                            {tms_r, tdi_r} <= drive_bits(op_r, len_r, cnt_r + CW'(1), data_r);
                        end else begin
                            div_r <= div_r + DW'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer with a behavioural TAP (16-state
// controller, 4-bit IR, 32-bit IDCODE data register) attached to tck/tms/tdi/tdo.
module tb_jtag_scan_sequencer;

    localparam int DR_MAX  = 32;
    localparam int CLK_DIV = 2;
    localparam int LW      = 6;

    localparam logic [31:0] IDCODE_VAL = 32'h4BA0_0477;
    localparam logic [3:0]  IR_IDCODE  = 4'b0001;
    localparam logic [3:0]  IR_CAPTURE = 4'b0101;

    localparam logic [3:0] S_TLR = 4'd0,  S_RTI = 4'd1,  S_SELDR = 4'd2,  S_CAPDR = 4'd3,
                           S_SHDR = 4'd4, S_EX1DR = 4'd5, S_PSDR = 4'd6,  S_EX2DR = 4'd7,
                           S_UPDR = 4'd8, S_SELIR = 4'd9, S_CAPIR = 4'd10, S_SHIR = 4'd11,
                           S_EX1IR = 4'd12, S_PSIR = 4'd13, S_EX2IR = 4'd14, S_UPIR = 4'd15;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    logic tck;
    logic tms;
    logic tdi;
    logic tdo = 1'b0;

    jtag_scan_sequencer_if #(.DR_MAX(DR_MAX), .LW(LW)) bus ();

    jtag_scan_sequencer #(.DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV), .LW(LW)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus),
        .tck     (tck),
        .tms     (tms),
        .tdi     (tdi),
        .tdo     (tdo)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- TAP model ----------------
    logic [3:0]  tap_st   = S_RTI;
    logic [3:0]  ir       = IR_IDCODE;
    logic [3:0]  ir_sr    = 4'd0;
    logic [31:0] dr_sr    = 32'd0;
    int          tck_cnt  = 0;
    logic [63:0] tms_hist = 64'd0;
    logic [63:0] tdi_hist = 64'd0;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            S_TLR:   return m ? S_TLR   : S_RTI;
            S_RTI:   return m ? S_SELDR : S_RTI;
            S_SELDR: return m ? S_SELIR : S_CAPDR;
            S_CAPDR: return m ? S_EX1DR : S_SHDR;
            S_SHDR:  return m ? S_EX1DR : S_SHDR;
            S_EX1DR: return m ? S_UPDR  : S_PSDR;
            S_PSDR:  return m ? S_EX2DR : S_PSDR;
            S_EX2DR: return m ? S_UPDR  : S_SHDR;
            S_UPDR:  return m ? S_SELDR : S_RTI;
            S_SELIR: return m ? S_TLR   : S_CAPIR;
            S_CAPIR: return m ? S_EX1IR : S_SHIR;
            S_SHIR:  return m ? S_EX1IR : S_SHIR;
            S_EX1IR: return m ? S_UPIR  : S_PSIR;
            S_PSIR:  return m ? S_EX2IR : S_PSIR;
            S_EX2IR: return m ? S_UPIR  : S_SHIR;
            default: return m ? S_SELDR : S_RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        tap_st   <= tap_next(tap_st, tms);
        tck_cnt  <= tck_cnt + 1;
        tms_hist <= {tms_hist[62:0], tms};
        tdi_hist <= {tdi_hist[62:0], tdi};
        case (tap_st)
            S_TLR:   ir    <= IR_IDCODE;
            S_CAPIR: ir_sr <= IR_CAPTURE;
            S_SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
            S_UPIR:  ir    <= ir_sr;
            S_CAPDR: dr_sr <= (ir == IR_IDCODE) ? IDCODE_VAL : 32'd0;
            S_SHDR:  dr_sr <= {tdi, dr_sr[31:1]};
            default: ;
        endcase
    end

    always @(negedge tck) begin
        tdo <= (tap_st == S_SHIR) ? ir_sr[0] : ((tap_st == S_SHDR) ? dr_sr[0] : 1'b0);
    end

    // ---------------- checking helpers ----------------
    int n_tests  = 0;
    int n_fail   = 0;
    int tck_base = 0;
    int lat      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [LW-1:0] len, input logic [31:0] data);
        int w;
        w = 0;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && (w < 200)) begin
            @(negedge sys_clk);
            w++;
        end
        check("hs_wait", 64'(w < 200), 64'd1);
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        tck_base      = tck_cnt;
        check("cmd_ready_drop", 64'(bus.cmd_ready), 64'd0);
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        do begin
            @(negedge sys_clk);
            l++;
        end while (!bus.rsp_valid && (l < 2000));
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge sys_clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
    endtask

    task automatic wait_sync(input string tag);
        int   n;
        logic saw_rsp;
        n       = 0;
        saw_rsp = 1'b0;
        while (!bus.cmd_ready && (n < 200)) begin
            @(negedge sys_clk);
            n++;
            saw_rsp = saw_rsp | bus.rsp_valid;
        end
        check({tag, "_ready_cycle"}, 64'(n), 64'd25);
        check({tag, "_tck_count"}, 64'(tck_cnt - tck_base), 64'd6);
        check({tag, "_tms_seq"}, 64'(tms_hist[5:0]), 64'(6'b111110));
        check({tag, "_tap_rti"}, 64'(tap_st), 64'(S_RTI));
        check({tag, "_no_rsp"}, 64'(saw_rsp), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] hold_data;
        logic        hold_err;
        logic        stable;
        int          w;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = 32'd0;
        bus.rsp_ready = 1'b0;

        // reset values
        repeat (3) @(negedge sys_clk);
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);

        // post-reset TLR
        tck_base = tck_cnt;
        reset    = 1'b0;
        wait_sync("sync");

        // IR scan loading IDCODE
        send(2'b01, 6'd4, 32'h0000_0001);
        wait_rsp(lat);
        check("ir_latency", 64'(lat), 64'd41);
        check("ir_tck_count", 64'(tck_cnt - tck_base), 64'd10);
        check("ir_tms_seq", 64'(tms_hist[9:0]), 64'(10'b1100000110));
        check("ir_tdi_seq", 64'(tdi_hist[9:0]), 64'(10'b0000100000));
        check("ir_rsp_data", 64'(bus.rsp_data), 64'h5);
        check("ir_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("ir_loaded", 64'(ir), 64'(IR_IDCODE));
        check("ir_tap_rti", 64'(tap_st), 64'(S_RTI));
        consume();

        // DR scan reading IDCODE
        send(2'b10, 6'd32, 32'hA5A5_0F0F);
        wait_rsp(lat);
        check("dr_latency", 64'(lat), 64'd149);
        check("dr_tck_count", 64'(tck_cnt - tck_base), 64'd37);
        check("dr_rsp_data", 64'(bus.rsp_data), 64'(IDCODE_VAL));
        check("dr_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("dr_tdi_shifted", 64'(dr_sr), 64'hA5A5_0F0F);
        check("dr_tap_rti", 64'(tap_st), 64'(S_RTI));
        consume();

        // rejected DR len 0
        send(2'b10, 6'd0, 32'hFFFF_FFFF);
        wait_rsp(lat);
        check("dr0_latency", 64'(lat), 64'd1);
        check("dr0_rsp_err", 64'(bus.rsp_err), 64'd1);
        check("dr0_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("dr0_no_tck", 64'(tck_cnt - tck_base), 64'd0);
        consume();

        // rejected IR len > DR_MAX
        send(2'b01, 6'd33, 32'h0000_0003);
        wait_rsp(lat);
        check("ir33_latency", 64'(lat), 64'd1);
        check("ir33_rsp_err", 64'(bus.rsp_err), 64'd1);
        check("ir33_no_tck", 64'(tck_cnt - tck_base), 64'd0);
        consume();

        // idle 3 with a back-pressured response
        send(2'b11, 6'd3, 32'd0);
        wait_rsp(lat);
        check("idle_latency", 64'(lat), 64'd13);
        check("idle_tck_count", 64'(tck_cnt - tck_base), 64'd3);
        check("idle_tms_seq", 64'(tms_hist[2:0]), 64'd0);
        check("idle_rsp_err", 64'(bus.rsp_err), 64'd0);
        hold_data = bus.rsp_data;
        hold_err  = bus.rsp_err;
        stable    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            stable = stable & bus.rsp_valid & (bus.rsp_data == hold_data) & (bus.rsp_err == hold_err)
                     & ~bus.cmd_ready & ~tck;
        end
        check("idle_hold_stable", 64'(stable), 64'd1);
        consume();

        // TLR command
        send(2'b00, 6'd9, 32'hFFFF_FFFF);
        wait_rsp(lat);
        check("tlr_latency", 64'(lat), 64'd25);
        check("tlr_tck_count", 64'(tck_cnt - tck_base), 64'd6);
        check("tlr_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));
        check("tlr_rsp_data", 64'(bus.rsp_data), 64'd0);
        consume();

        // idle 0 answers immediately
        send(2'b11, 6'd0, 32'd0);
        wait_rsp(lat);
        check("idle0_latency", 64'(lat), 64'd1);
        check("idle0_rsp_err", 64'(bus.rsp_err), 64'd0);
        consume();

        // reset during DR shift bit 10 (tck index 13)
        send(2'b10, 6'd32, 32'h1234_5678);
        w = 0;
        while (((tck_cnt - tck_base) < 14) && (w < 200)) begin
            @(negedge sys_clk);
            w++;
        end
        check("mid_reach_bit10", 64'(tck_cnt - tck_base), 64'd14);
        check("mid_tap_shdr", 64'(tap_st), 64'(S_SHDR));
        reset = 1'b1;
        @(negedge sys_clk);
        check("mid_tck_low", 64'(tck), 64'd0);
        check("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
        check("mid_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        tck_base = tck_cnt;
        reset    = 1'b0;
        wait_sync("resync");

        // normal operation after the abandoned scan
        send(2'b10, 6'd32, 32'd0);
        wait_rsp(lat);
        check("post_dr_latency", 64'(lat), 64'd149);
        check("post_dr_rsp_data", 64'(bus.rsp_data), 64'(IDCODE_VAL));
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
